// File: rtl/nibble_serial_adder.sv
// Adds two W-bit operands (W = 4*NIBBLES) one nibble per clock through a
// single four_bit_adder_nor stage. Optional macro NSA_OVERFLOW_EN adds o_ovf.

module four_bit_adder_nor (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] w_c;
  assign w_c[0] = cin;

  for (genvar g = 0; g < 4; g++) begin : g_bit
    logic w_n1, w_n2, w_n3, w_xn, w_m1, w_m2, w_m3;
    // XNOR(a,b) from four NORs, then XNOR(xnor_ab, c) gives a^b^c
    assign w_n1 = ~(a[g] | b[g]);
    assign w_n2 = ~(a[g] | w_n1);
    assign w_n3 = ~(b[g] | w_n1);
    assign w_xn = ~(w_n2 | w_n3);
    assign w_m1 = ~(w_xn | w_c[g]);
    assign w_m2 = ~(w_xn | w_m1);
    assign w_m3 = ~(w_c[g] | w_m1);
    assign sum[g] = ~(w_m2 | w_m3);
    // Majority carry as a NOR of three pairwise NORs
    assign w_c[g+1] = ~(w_n1 | ~(b[g] | w_c[g]) | ~(a[g] | w_c[g]));
  end

  assign cout = w_c[4];
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [4*NIBBLES-1:0] i_a,
  input  logic [4*NIBBLES-1:0] i_b,
  input  logic                 i_cin,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [4*NIBBLES-1:0] o_sum,
`ifdef NSA_OVERFLOW_EN
  output logic                 o_ovf,
`endif
  output logic                 o_cout
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  logic [W-1:0]  r_opa, r_opb, r_acc, r_sum;
  logic [CW-1:0] r_cnt;
  logic          r_carry, r_cout, r_busy, r_done;
  logic [3:0]    w_nsum;
  logic          w_ncout;
  logic [W-1:0]  w_acc_nxt;

  four_bit_adder_nor u_add (
    .a    (r_opa[3:0]),
    .b    (r_opb[3:0]),
    .cin  (r_carry),
    .sum  (w_nsum),
    .cout (w_ncout)
  );

  // Accumulator with this cycle's nibble merged in, so the final commit
  // to r_sum includes the last nibble.
  always_comb begin
    w_acc_nxt = r_acc;
    w_acc_nxt[{r_cnt, 2'b00} +: 4] = w_nsum;
  end

`ifdef NSA_OVERFLOW_EN
  logic r_amsb, r_bmsb, r_ovf;
  assign o_ovf = r_ovf;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef NSA_OVERFLOW_EN
      r_amsb  <= 1'b0;
      r_bmsb  <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_opa   <= i_a;
            r_opb   <= i_b;
            r_carry <= i_cin;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
`ifdef NSA_OVERFLOW_EN
            r_amsb  <= i_a[W-1];
            r_bmsb  <= i_b[W-1];
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_nxt;
          r_carry <= w_ncout;
          r_opa   <= r_opa >> 4;
          r_opb   <= r_opb >> 4;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_sum   <= w_acc_nxt;
            r_cout  <= w_ncout;
`ifdef NSA_OVERFLOW_EN
            r_ovf   <= (r_amsb == r_bmsb) && (w_acc_nxt[W-1] != r_amsb);
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;
endmodule
